serial_adder_n: RTL and testbench

Parametrised multi-cycle adder/subtractor. It reuses one DIGIT-bit full-adder slice across WIDTH/DIGIT clock cycles, LSB digit first, under a start/busy/done handshake. It is the sequential, width-generalised successor to the single-bit full adder. It sits in the datapath experiments as the ALU add path where area matters more than latency.

---
 rtl/serial_adder_n.sv | 127 ++++++++++++
 tb/tb_serial_adder_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT cycles, LSB digit first.
// Define SERIAL_ADDER_FLAGS_EN to build the OV/ZF flag logic; otherwise both flags are tied to 0.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             OV,
  output logic             ZF,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT-1:0] digit_sum;
  logic             carry_chain;
  logic             carry_out;
  logic [WIDTH-1:0] sum_next;
  logic             last;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             carry_msb_in;
`endif

  // Ripple through the current digit; carry_msb_in ends up as the carry into its top bit.
  always_comb begin
    carry_chain = carry_reg;
    digit_sum   = '0;
`ifdef SERIAL_ADDER_FLAGS_EN
    carry_msb_in = carry_reg;
`endif
    for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDER_FLAGS_EN
      carry_msb_in = carry_chain;
`endif
      digit_sum[i] = a_reg[i] ^ b_reg[i] ^ carry_chain;
      carry_chain  = (a_reg[i] & b_reg[i]) | (carry_chain & (a_reg[i] ^ b_reg[i]));
    end
    carry_out = carry_chain;
  end

  always_comb begin
    sum_next = sum_reg >> DIGIT;
    sum_next[WIDTH-1 -: DIGIT] = digit_sum;
  end

  assign last = (cnt_reg == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      F         <= '0;
      Cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= Sub ? ~B : B;
            carry_reg <= Cin ^ Sub;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          sum_reg   <= sum_next;
          carry_reg <= carry_out;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last) begin
            F     <= sum_next;
            Cout  <= carry_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OV <= 1'b0;
      ZF <= 1'b0;
    end else if (state == RUN && last) begin
      OV <= carry_msb_in ^ carry_out;
      ZF <= (sum_next == '0);
    end
  end
`else
  assign OV = 1'b0;
  assign ZF = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: directed cases, handshake/reset, random 8-bit and exhaustive 4-bit.
// Flag expectations follow SERIAL_ADDER_FLAGS_EN, matching whichever build is compiled.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, f8;
  logic       co8, ov8, zf8, busy8, done8;

  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, f4;
  logic       co4, ov4, zf4, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;
  int exp_prev8 = 0;
  int exp_prev4 = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .Sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .F(f8), .Cout(co8), .OV(ov8), .ZF(zf8), .busy(busy8), .done(done8)
  );

  serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .Sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .F(f4), .Cout(co4), .OV(ov4), .ZF(zf4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the stated add/subtract rules.
  function automatic void model(input int w, input bit sub, input int a, input int b, input bit cin,
                                output int f, output bit co, output bit ov);
    int mask, full, sa, sb, sr;
    mask = (1 << w) - 1;
    if (!sub) full = a + b + int'(cin);
    else      full = a + (~b & mask) + (cin ? 0 : 1);
    f  = full & mask;
    co = ((full >> w) & 1) != 0;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = sub ? sa - sb - int'(cin) : sa + sb + int'(cin);
    ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
  endfunction

  // Called just after a negedge; returns just after the negedge following the done cycle.
  task automatic run_op(input bit sel, input bit sub, input int a, input int b, input bit cin, input bit hold);
    int    w, n, ef, busy_cnt, done_cnt, done_at, rf, prev;
    bit    eco, eov, ezf, hold_ok, o_busy, o_done, rco, rov, rzf;
    int    o_f;
    string tag;
    w = sel ? 4 : 8;
    n = sel ? 2 : 8;
    model(w, sub, a, b, cin, ef, eco, eov);
`ifdef SERIAL_ADDER_FLAGS_EN
    ezf = (ef == 0);
`else
    eov = 1'b0;
    ezf = 1'b0;
`endif
    prev = sel ? exp_prev4 : exp_prev8;
    tag = $sformatf("w%0d %s a=%0h b=%0h cin=%0d", w, sub ? "sub" : "add", a, b, cin);
    if (sel) begin
      a4 = a[3:0]; b4 = b[3:0]; sub4 = sub; cin4 = cin; start4 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; cin8 = cin; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin start4 = 1'b0; start8 = 1'b0; end
    // Scramble operands after capture; they must not affect the result.
    a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    sub4 = ~sub4; sub8 = ~sub8; cin4 = ~cin4; cin8 = ~cin8;
    busy_cnt = 0; done_cnt = 0; done_at = 0; hold_ok = 1'b1;
    rf = 0; rco = 1'b0; rov = 1'b0; rzf = 1'b0;
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clk);
      o_busy = sel ? busy4 : busy8;
      o_done = sel ? done4 : done8;
      o_f    = sel ? int'(f4) : int'(f8);
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = j;
      end
      if (j <= n && o_f != prev) hold_ok = 1'b0;
      if (j == n + 1) begin
        rf  = o_f;
        rco = sel ? co4 : co8;
        rov = sel ? ov4 : ov8;
        rzf = sel ? zf4 : zf8;
      end
      if (j == n + 2) begin start4 = 1'b0; start8 = 1'b0; end
    end
    check({tag, " busy_cycles"}, busy_cnt, n);
    check({tag, " done_at"}, done_at, n + 1);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " F_hold"}, {31'd0, hold_ok}, 1);
    check({tag, " F"}, rf, ef);
    check({tag, " Cout"}, {31'd0, rco}, {31'd0, eco});
    check({tag, " OV"}, {31'd0, rov}, {31'd0, eov});
    check({tag, " ZF"}, {31'd0, rzf}, {31'd0, ezf});
    if (sel) exp_prev4 = ef; else exp_prev8 = ef;
    $display("op %s -> F=%0h Cout=%0d OV=%0d ZF=%0d", tag, rf, rco, rov, rzf);
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset F", f8, 0);
    check("reset Cout", co8, 0);
    check("reset OV", ov8, 0);
    check("reset ZF", zf8, 0);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset F4", f4, 0);

    // Directed arithmetic cases
    run_op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 8'h03, 8'h05, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0);

    // start held through RUN and DONE: exactly one operation
    run_op(1'b0, 1'b0, 8'h3C, 8'h21, 1'b0, 1'b1);
    nd = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (busy8 || done8) nd++;
    end
    check("hold_start no_second_op", nd, 0);

    // Reset mid-RUN aborts with no done pulse
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid F", f8, 0);
    check("rst_mid Cout", co8, 0);
    check("rst_mid OV", ov8, 0);
    check("rst_mid ZF", zf8, 0);
    check("rst_mid busy", busy8, 0);
    check("rst_mid done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_prev8 = 0;
    exp_prev4 = 0;
    nd = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    check("rst_mid no_done", nd, 0);
    run_op(1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0);

    // Random 8-bit operations
    for (int i = 0; i < 40; i++)
      run_op(1'b0, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'($urandom), 1'b0);

    // Exhaustive WIDTH=4, DIGIT=2
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            run_op(1'b1, s[0], a, b, c[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
